// File: rtl/bitnet_medium_pkg.sv
// Shared types for the instruction loader.
//
// loader_state_t : loader control states
//   IDLE - waiting for a start request; host words are not consumed
//   LOAD - accepting words and writing them to consecutive BRAM addresses
//   DONE - single-cycle completion state (done pulse, CPU still held)
package bitnet_medium_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } loader_state_t;

endpackage : bitnet_medium_pkg

// File: rtl/instruction_loader_medium.sv
// Instruction loader: streams instruction words from a host source into the
// instruction BRAM starting at address 0, holding the CPU while a load is in
// progress. Reports completion, the word count and a wrapping checksum.
//
// Ports:
//   clk_in, rst_in        clock and synchronous active-high reset
//   load_start_in         one-cycle start request (honoured only in IDLE)
//   load_len_in           words to load, clamped to ADDRS, sampled at start
//   data_in/data_valid_in host word and its valid
//   data_ready_out        loader accepts a word this cycle (LOAD only)
//   busy_out/cpu_hold_out high in LOAD and DONE
//   done_out              one-cycle pulse when a load finishes
//   words_loaded_out      words written in the current or last load
//   checksum_out          sum of loaded words modulo 2^BRAM_WIDTH
//   bram_*                write-only BRAM port (read data is ignored)
module instruction_loader_medium
    import bitnet_medium_pkg::*;
#(
    parameter int ADDRS      = 256,
    parameter int BRAM_WIDTH = 8,
    localparam int ADDR_SIZE = $clog2(ADDRS)
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  load_start_in,
    input  logic [ADDR_SIZE:0]    load_len_in,
    input  logic [BRAM_WIDTH-1:0] data_in,
    input  logic                  data_valid_in,
    output logic                  data_ready_out,
    output logic                  busy_out,
    output logic                  cpu_hold_out,
    output logic                  done_out,
    output logic [ADDR_SIZE:0]    words_loaded_out,
    output logic [BRAM_WIDTH-1:0] checksum_out,
    input  logic [BRAM_WIDTH-1:0] bram_dout,
    output logic [ADDR_SIZE-1:0]  bram_addr,
    output logic                  bram_we,
    output logic                  bram_regce,
    output logic [BRAM_WIDTH-1:0] bram_din
);

    localparam int LEN_W = ADDR_SIZE + 1;
    localparam logic [LEN_W-1:0]     MAX_LEN  = LEN_W'(ADDRS);
    localparam logic [LEN_W-1:0]     ONE_LEN  = LEN_W'(1);
    localparam logic [ADDR_SIZE-1:0] ONE_ADDR = ADDR_SIZE'(1);

    loader_state_t         state_q, state_d;
    logic [ADDR_SIZE-1:0]  wr_addr_q, wr_addr_d;
    logic [LEN_W-1:0]      remaining_q, remaining_d;
    logic [LEN_W-1:0]      words_q, words_d;
    logic [BRAM_WIDTH-1:0] checksum_q, checksum_d;

    logic             beat;
    logic [LEN_W-1:0] clamped_len;

    // The loader never reads the BRAM; the read port exists only so the
    // memory can be shared with the fetch side.
    logic bram_dout_unused;
    assign bram_dout_unused = ^bram_dout;

    // A beat is a word transfer; ready is only ever high in LOAD.
    assign beat = (state_q == LOAD) && data_valid_in;

    // Clamping the length keeps wr_addr inside the BRAM: the last write of
    // a full-depth load lands on ADDRS-1.
    assign clamped_len = (load_len_in > MAX_LEN) ? MAX_LEN : load_len_in;

    always_comb begin
        state_d     = state_q;
        wr_addr_d   = wr_addr_q;
        remaining_d = remaining_q;
        words_d     = words_q;
        checksum_d  = checksum_q;

        case (state_q)
            IDLE: begin
                if (load_start_in) begin
                    wr_addr_d   = '0;
                    remaining_d = clamped_len;
                    words_d     = '0;
                    checksum_d  = '0;
                    // A zero-length load still reports completion.
                    state_d     = (clamped_len != '0) ? LOAD : DONE;
                end
            end
            LOAD: begin
                if (beat) begin
                    wr_addr_d   = wr_addr_q + ONE_ADDR;
                    remaining_d = remaining_q - ONE_LEN;
                    words_d     = words_q + ONE_LEN;
                    checksum_d  = checksum_q + data_in;
                    if (remaining_q == ONE_LEN) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q     <= IDLE;
            wr_addr_q   <= '0;
            remaining_q <= '0;
            words_q     <= '0;
            checksum_q  <= '0;
        end else begin
            state_q     <= state_d;
            wr_addr_q   <= wr_addr_d;
            remaining_q <= remaining_d;
            words_q     <= words_d;
            checksum_q  <= checksum_d;
        end
    end

    // Handshake and status are pure functions of the state register.
    assign data_ready_out   = (state_q == LOAD);
    assign busy_out         = (state_q == LOAD) || (state_q == DONE);
    assign cpu_hold_out     = busy_out;
    assign done_out         = (state_q == DONE);
    assign words_loaded_out = words_q;
    assign checksum_out     = checksum_q;

    // The write happens in the same cycle as the beat; data is zeroed
    // outside a beat so the BRAM port is quiet between writes.
    assign bram_we    = beat;
    assign bram_addr  = (state_q == LOAD) ? wr_addr_q : '0;
    assign bram_din   = beat ? data_in : '0;
    assign bram_regce = 1'b0;

endmodule : instruction_loader_medium
